// File: rtl/sd_spi_master_pkg.sv
// Shared definitions for the SD card SPI byte engine: register map,
// STATUS bit positions and the shifter state encoding.
package sd_spi_master_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_RXV_BIT   = 1;
  localparam int ST_OVR_BIT   = 2;
  localparam int ST_IRQEN_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte shifter: half-period timing, bit counting, the shift
// register and the sclk/mosi pins. MSB first; MISO is captured on the clk
// edge that raises sclk. The FSM state is exported so the top level (and
// any bound checker) can observe it directly.
module sd_spi_shifter
  import sd_spi_master_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [7:0]       tx_byte_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             miso_i,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic             done_o,
  output logic [7:0]       shift_o,
  output logic [1:0]       state_o
);

  spi_state_e       state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_act_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             half_done;

  // A half period ends after div_act+1 cycles in LOW or HIGH.
  assign half_done = (cnt_q == div_act_q);
  // Last falling edge of the byte: the top level latches shift_o on it.
  assign done_o    = (state_q == HIGH) && half_done && (bit_q == 3'd7);
  assign shift_o   = shift_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign state_o   = state_q;

  // Byte FSM: IDLE waits for a start, LOW/HIGH alternate every half period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_act_q <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_q   <= tx_byte_i;
            mosi_q    <= tx_byte_i[7];
            div_act_q <= div_i;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            state_q   <= LOW;
          end
        end
        LOW: begin
          if (half_done) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b1;
            shift_q <= {shift_q[6:0], miso_i};
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        HIGH: begin
          if (half_done) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == 3'd7) begin
              mosi_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              // After the capture shift, bit 7 holds the next bit to send.
              mosi_q  <= shift_q[7];
              bit_q   <= bit_q + 3'd1;
              state_q <= LOW;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// Avalon-MM SPI byte engine for the SD card slot. Holds the register decode,
// status flags, the SCLK divisor and the readdata mux; the bit timing lives
// in sd_spi_shifter.
// Bus handshake: a write takes effect on the edge where chipselect & ~write_n
// is sampled; a read returns data combinationally from address, and its only
// side effect (DATA clears rx_valid) happens on the edge where
// chipselect & ~read_n is sampled. There are no wait states.
module sd_spi_master
  import sd_spi_master_pkg::*;
#(
  parameter int               DIV_W       = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 8'd124
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  logic [DIV_W-1:0] div_q;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             overrun_q;
  logic             irq_en_q;

  logic             wr, rd;
  logic             wr_data, wr_status, wr_div, rd_data;
  logic             busy, start, done;
  logic [7:0]       shift;
  logic [1:0]       shifter_state;
  logic             unused_wdata;

  assign wr        = chipselect && !write_n;
  assign rd        = chipselect && !read_n;
  assign wr_data   = wr && (address == ADDR_DATA);
  assign wr_status = wr && (address == ADDR_STATUS);
  assign wr_div    = wr && (address == ADDR_DIV);
  assign rd_data   = rd && (address == ADDR_DATA);
  assign busy      = (shifter_state != IDLE);
  assign start     = wr_data && !busy;
  assign irq       = rx_valid_q && irq_en_q;
  assign unused_wdata = ^writedata;

  sd_spi_shifter #(.DIV_W(DIV_W)) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (start),
    .tx_byte_i (writedata[7:0]),
    .div_i     (div_q),
    .miso_i    (miso),
    .sclk_o    (sclk),
    .mosi_o    (mosi),
    .done_o    (done),
    .shift_o   (shift),
    .state_o   (shifter_state)
  );

  // Control/status registers. Set events win over same-cycle clears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q      <= DEFAULT_DIV;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      if (wr_div)    div_q    <= writedata[DIV_W-1:0];
      if (wr_status) irq_en_q <= writedata[ST_IRQEN_BIT];
      if (done) begin
        rx_byte_q  <= shift;
        rx_valid_q <= 1'b1;
      end else if (rd_data) begin
        rx_valid_q <= 1'b0;
      end
      if (wr_data && busy) begin
        overrun_q <= 1'b1;
      end else if (wr_status && writedata[ST_OVR_BIT]) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Zero-latency read mux; unused bits read as 0.
  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_DATA:   readdata = {24'h0, rx_byte_q};
      ADDR_STATUS: readdata = {28'h0, irq_en_q, overrun_q, rx_valid_q, busy};
      ADDR_DIV:    readdata = {{(32-DIV_W){1'b0}}, div_q};
      default:     readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master with a transfer-level reference model.
module tb_sd_spi_master;
  import sd_spi_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = ADDR_STATUS;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        irq, sclk, mosi;
  logic        miso = 1'b0;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sd_spi_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transfer is described by its start, divisor and bytes; the pin
  // waveform is derived from the cycle offset m_s within the 16 half periods.
  bit         m_active = 0;
  int         m_s = 0;
  int         m_da = 0;
  logic [7:0] m_tx = 8'h00, m_rx_exp = 8'h00, m_rx_byte = 8'h00;
  bit         m_rxv = 0, m_ovr = 0, m_irqen = 0;
  logic [7:0] m_div = 8'd124;
  logic [7:0] miso_byte = 8'h00;
  bit         cmp_en = 0;

  always @(posedge clk) begin : model_p
    bit was, done, wr, rd;
    if (!reset_n) begin
      m_active = 0; m_s = 0; m_rx_byte = 8'h00;
      m_rxv = 0; m_ovr = 0; m_irqen = 0; m_div = 8'd124;
    end else begin
      wr   = chipselect && !write_n;
      rd   = chipselect && !read_n;
      was  = m_active;
      done = m_active && (m_s == 16 * (m_da + 1) - 1);
      if (rd && address == ADDR_DATA) m_rxv = 0;
      if (wr && address == ADDR_STATUS) begin
        m_irqen = writedata[3];
        if (writedata[2]) m_ovr = 0;
      end
      if (wr && address == ADDR_DIV) m_div = writedata[7:0];
      if (m_active) begin
        if (done) begin
          m_active = 0; m_rx_byte = m_rx_exp; m_rxv = 1;
        end else begin
          m_s++;
        end
      end
      if (wr && address == ADDR_DATA) begin
        if (was) m_ovr = 1;
        else begin
          m_active = 1; m_s = 0; m_tx = writedata[7:0];
          m_da = int'(m_div); m_rx_exp = miso_byte;
        end
      end
    end
  end

  // Card model: present bit (7 - bit index) for the whole bit window.
  always @(posedge clk) begin
    #1;
    if (m_active) miso = miso_byte[7 - (m_s / (m_da + 1)) / 2];
    else          miso = 1'b0;
  end

  // ---------------- compare process ----------------
  logic [31:0] exp_rd;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sclk", 32'(sclk), m_active ? 32'((m_s / (m_da + 1)) % 2) : 32'd0);
      chk("mosi", 32'(mosi), m_active ? 32'(m_tx[7 - (m_s / (m_da + 1)) / 2]) : 32'd1);
      chk("irq",  32'(irq),  32'(m_rxv && m_irqen));
      case (address)
        ADDR_DATA:   exp_rd = {24'h0, m_rx_byte};
        ADDR_STATUS: exp_rd = {28'h0, m_irqen, m_ovr, m_rxv, m_active};
        ADDR_DIV:    exp_rd = {24'h0, m_div};
        default:     exp_rd = 32'h0;
      endcase
      chk("readdata", readdata, exp_rd);
    end
  end

  // MOSI values seen at each sclk rise, when logging is enabled.
  bit         log_en = 0;
  logic       prev_sclk = 1'b0;
  logic       got_q[$];
  always @(negedge clk) begin
    if (log_en && sclk && !prev_sclk) got_q.push_back(mosi);
    prev_sclk = sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1; address = ADDR_STATUS;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!readdata[0]) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  // Counts busy cycles (and sclk-high cycles) of the transfer in progress.
  task automatic count_busy(output int nb, output int nh);
    nb = 0; nh = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!readdata[0]) break;
      nb++;
      if (sclk) nh++;
    end
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] v;
  int nb, nh;
  logic exp_q[$];

  initial begin
    repeat (3) @(posedge clk);
    #1 cmp_en = 1;
    @(posedge clk); #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd1);
    bus_read(ADDR_STATUS, v); chk("rst_status", v, 32'h0);
    bus_read(ADDR_DIV, v);    chk("rst_div", v, 32'd124);
    bus_read(ADDR_DATA, v);   chk("rst_data", v, 32'h0);
    bus_read(2'd3, v);        chk("rsvd_read", v, 32'h0);

    // DIV = 0, 0xA5 out, 0x3C back
    bus_write(ADDR_DIV, 32'd0);
    miso_byte = 8'h3C;
    got_q.delete(); log_en = 1;
    bus_write(ADDR_DATA, 32'hA5);
    count_busy(nb, nh);
    log_en = 0;
    chk("a5_busy_len", 32'(nb), 32'd16);
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    chk("a5_rise_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) chk("a5_mosi_bit", 32'(got_q[i]), 32'(exp_q[i]));
    bus_read(ADDR_STATUS, v); chk("a5_rxvalid", v, 32'h2);
    bus_read(ADDR_DATA, v);   chk("a5_rxbyte", v, 32'h3C);
    bus_read(ADDR_STATUS, v); chk("a5_rxv_clr", v, 32'h0);

    // DIV = 3, 0xFF: 4-cycle half periods, 64-cycle byte
    bus_write(ADDR_DIV, 32'd3);
    miso_byte = 8'h81;
    bus_write(ADDR_DATA, 32'hFF);
    count_busy(nb, nh);
    chk("ff_busy_len", 32'(nb), 32'd64);
    chk("ff_sclk_high", 32'(nh), 32'd32);
    bus_read(ADDR_DATA, v); chk("ff_rxbyte", v, 32'h81);

    // Overrun: second DATA write while busy is dropped
    bus_write(ADDR_DIV, 32'd1);
    miso_byte = 8'h5A;
    bus_write(ADDR_DATA, 32'hC3);
    bus_write(ADDR_DATA, 32'h12);
    bus_read(ADDR_STATUS, v); chk("ovr_status", v, 32'h5);
    wait_idle(200);
    bus_read(ADDR_DATA, v);   chk("ovr_rxbyte", v, 32'h5A);
    bus_write(ADDR_STATUS, 32'h4);
    bus_read(ADDR_STATUS, v); chk("ovr_clear", v, 32'h0);

    // irq: rises at completion, drops on DATA read
    bus_write(ADDR_STATUS, 32'h8);
    bus_write(ADDR_DIV, 32'd0);
    miso_byte = 8'hE7;
    bus_write(ADDR_DATA, 32'h3C);
    wait_idle(100);
    chk("irq_high", 32'(irq), 32'd1);
    bus_read(ADDR_DATA, v);   chk("irq_rxbyte", v, 32'hE7);
    @(negedge clk);
    chk("irq_low", 32'(irq), 32'd0);

    // DATA read on the completion edge: set wins
    miso_byte = 8'h99;
    bus_write(ADDR_DATA, 32'h55);
    repeat (14) @(posedge clk);
    bus_read(ADDR_DATA, v);   chk("cc_old_byte", v, 32'hE7);
    bus_read(ADDR_STATUS, v); chk("cc_status", v, 32'hA);
    chk("cc_irq", 32'(irq), 32'd1);
    bus_read(ADDR_DATA, v);   chk("cc_new_byte", v, 32'h99);

    // DATA write on the completion edge: ignored, overrun set
    bus_write(ADDR_STATUS, 32'h0);
    miso_byte = 8'h0F;
    bus_write(ADDR_DATA, 32'h81);
    repeat (14) @(posedge clk);
    bus_write(ADDR_DATA, 32'h77);
    bus_read(ADDR_STATUS, v); chk("cw_status", v, 32'h6);
    bus_write(ADDR_STATUS, 32'h4);
    bus_read(ADDR_DATA, v);   chk("cw_rxbyte", v, 32'h0F);

    // Reset mid-byte
    bus_write(ADDR_DIV, 32'd2);
    miso_byte = 8'hFF;
    bus_write(ADDR_DATA, 32'hF0);
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_sclk", 32'(sclk), 32'd0);
    chk("mrst_mosi", 32'(mosi), 32'd1);
    bus_read(ADDR_STATUS, v); chk("mrst_status", v, 32'h0);
    bus_read(ADDR_DIV, v);    chk("mrst_div", v, 32'd124);
    bus_read(ADDR_DATA, v);   chk("mrst_data", v, 32'h0);
    miso_byte = 8'h24;
    bus_write(ADDR_DATA, 32'h40);
    count_busy(nb, nh);
    chk("post_busy_len", 32'(nb), 32'd2000);
    bus_read(ADDR_DATA, v);   chk("post_rxbyte", v, 32'h24);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
